// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: FSM states,
// per-stage stall masks and the request merge helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_FLUSH  = 2'd1,
    PC_REFILL = 2'd2
  } pc_state_e;

  // stall[n]=1 with stall[n+1]=0 inserts a bubble into stage n+1
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Masks are nested, so the deepest requester alone sets the result.
  function automatic logic [5:0] merge_stall(input logic req_if, input logic req_id,
                                             input logic req_ex, input logic req_mem);
    logic [5:0] m;
    m = STALL_NONE;
    if (req_mem)     m = STALL_MEM;
    else if (req_ex) m = STALL_EX;
    else if (req_id) m = STALL_ID;
    else if (req_if) m = STALL_IF;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Tracks PC-stall activity: consecutive-cycle watchdog with a single timeout
// pulse per stall episode, plus a free-running total of stalled cycles.
module pipeline_ctrl_stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_PRE = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  always_comb begin
    wd_cnt_d    = wd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!stall_pc) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    if (stall_pc) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q    <= '0;
      stall_cnt_q <= ZERO_WORD;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Fires in the stalled cycle that brings the run length up to TIMEOUT;
  // saturation at WD_MAX keeps it from firing again in the same episode.
  assign stall_timeout = stall_pc && !rst && (wd_cnt_q == WD_PRE);
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests and sequences
// exception redirects as freeze -> flush -> I-side refill.
//   state     | meaning
//   PC_RUN    | normal operation, stall = merged requests
//   PC_FLUSH  | one cycle, flush=1 with redirect target on new_pc
//   PC_REFILL | PC+IF held while fetch restarts at the new target
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REFILL_CYCLES = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cnt
);

  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFILL_CYCLES - 1);

  pc_state_e       state_q, state_d;
  logic [RC_W-1:0] refill_cnt_q, refill_cnt_d;
  logic            flush_q, flush_d;
  logic [31:0]     new_pc_q, new_pc_d;

  always_comb begin
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    new_pc_d     = new_pc_q;
    stall        = STALL_NONE;

    unique case (state_q)
      PC_RUN: begin
        stall = merge_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
      end
      PC_FLUSH: begin
        state_d      = PC_REFILL;
        refill_cnt_d = RC_LOAD;
      end
      PC_REFILL: begin
        stall = STALL_IF | merge_stall(1'b0, stallreq_id, stallreq_ex, stallreq_mem);
        if (refill_cnt_q == '0) begin
          state_d = PC_RUN;
        end else begin
          refill_cnt_d = refill_cnt_q - RC_W'(1);
        end
      end
      default: begin
        state_d = PC_RUN;
      end
    endcase

    // A new exception overrides whatever sequence is in progress.
    if (flush_req) begin
      stall    = STALL_ALL;
      state_d  = PC_FLUSH;
      new_pc_d = flush_pc;
    end

    flush_d = (state_d == PC_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PC_RUN;
      refill_cnt_q <= '0;
      flush_q      <= 1'b0;
      new_pc_q     <= ZERO_WORD;
    end else begin
      state_q      <= state_d;
      refill_cnt_q <= refill_cnt_d;
      flush_q      <= flush_d;
      new_pc_q     <= new_pc_d;
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

  pipeline_ctrl_stall_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_pc     (stall[0]),
    .stall_timeout(stall_timeout),
    .stall_cnt    (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int REFILL_CYCLES = 2;
  localparam int TIMEOUT       = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  bit          m_in_flush = 1'b0;
  int          m_refill_left = 0;
  logic [31:0] m_pc = 32'h0;
  int          m_consec = 0;
  logic [31:0] m_stall_cnt = 32'h0;

  logic [5:0]  exp_stall;
  logic        exp_flush;
  logic [31:0] exp_new_pc;
  logic        exp_timeout;
  logic [31:0] exp_stall_cnt;

  pipeline_ctrl #(
    .REFILL_CYCLES(REFILL_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  // number of held stages starting from PC
  function automatic logic [5:0] hold_mask(input int depth);
    return 6'((1 << depth) - 1);
  endfunction

  task automatic eval_model();
    int depth;
    depth = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : 0;
    if (flush_req)              exp_stall = 6'h3f;
    else if (m_in_flush)        exp_stall = 6'h00;
    else if (m_refill_left > 0) exp_stall = hold_mask(depth > 2 ? depth : 2);
    else                        exp_stall = hold_mask((stallreq_if && depth == 0) ? 2 : depth);
    exp_flush     = m_in_flush;
    exp_new_pc    = m_pc;
    exp_stall_cnt = m_stall_cnt;
    exp_timeout   = !rst && exp_stall[0] && (m_consec == TIMEOUT - 1);
  endtask

  task automatic tick();
    eval_model();
    @(posedge clk);
    if (rst) begin
      m_in_flush = 0; m_refill_left = 0; m_pc = 32'h0; m_consec = 0; m_stall_cnt = 32'h0;
    end else begin
      if (exp_stall[0]) begin
        m_stall_cnt = m_stall_cnt + 32'd1;
        m_consec    = (m_consec < TIMEOUT) ? m_consec + 1 : TIMEOUT;
      end else begin
        m_consec = 0;
      end
      if (flush_req) begin
        m_pc = flush_pc; m_in_flush = 1; m_refill_left = 0;
      end else if (m_in_flush) begin
        m_in_flush = 0; m_refill_left = REFILL_CYCLES;
      end else if (m_refill_left > 0) begin
        m_refill_left--;
      end
    end
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    eval_model();
  endtask

  task automatic set_in(input bit r_if, input bit r_id, input bit r_ex, input bit r_mem,
                        input bit f_req, input logic [31:0] f_pc);
    stallreq_if = r_if; stallreq_id = r_id; stallreq_ex = r_ex; stallreq_mem = r_mem;
    flush_req = f_req; flush_pc = f_pc;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_checks++; if (stall !== 6'b000000) $display("FAIL reset_stall: got %b want %b", stall, 6'b000000); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else n_pass++;
    n_checks++; if (new_pc !== 32'h0) $display("FAIL reset_new_pc: got %h want 0", new_pc); else n_pass++;
    n_checks++; if (stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (stall_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", stall_timeout); else n_pass++;
    tick();
  endtask

  task automatic test_merge();
    set_in(0, 1, 0, 1, 0, 32'h0); settle();
    n_checks++; if (stall !== 6'b011111) $display("FAIL merge_id_mem: got %b want %b", stall, 6'b011111); else n_pass++;
    tick();
    set_in(0, 1, 0, 0, 0, 32'h0); settle();
    n_checks++; if (stall !== 6'b000111) $display("FAIL merge_id: got %b want %b", stall, 6'b000111); else n_pass++;
    tick();
    set_in(1, 0, 0, 0, 0, 32'h0); settle();
    n_checks++; if (stall !== 6'b000011) $display("FAIL merge_if: got %b want %b", stall, 6'b000011); else n_pass++;
    tick();
    set_in(1, 1, 1, 0, 0, 32'h0); settle();
    n_checks++; if (stall !== 6'b001111) $display("FAIL merge_if_id_ex: got %b want %b", stall, 6'b001111); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 32'h0); settle();
    n_checks++; if (stall_cnt !== 32'd4) $display("FAIL merge_stall_cnt: got %0d want 4", stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_flush_seq();
    set_in(0, 0, 0, 0, 1, 32'h0000_0040); settle();
    n_checks++; if (stall !== 6'b111111) $display("FAIL flush_freeze: got %b want %b", stall, 6'b111111); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL flush_not_early: got %b want 0", flush); else n_pass++;
    tick();
    set_in(0, 1, 1, 1, 0, 32'hdead_beef); settle();
    n_checks++; if (flush !== 1'b1) $display("FAIL flush_pulse: got %b want 1", flush); else n_pass++;
    n_checks++; if (new_pc !== 32'h40) $display("FAIL flush_new_pc: got %h want %h", new_pc, 32'h40); else n_pass++;
    n_checks++; if (stall !== 6'b000000) $display("FAIL flush_stall_ignored: got %b want 0", stall); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 32'h0); settle();
    n_checks++; if (stall !== 6'b000011) $display("FAIL refill_1: got %b want %b", stall, 6'b000011); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL refill_flush_low: got %b want 0", flush); else n_pass++;
    n_checks++; if (new_pc !== 32'h40) $display("FAIL refill_new_pc_hold: got %h want %h", new_pc, 32'h40); else n_pass++;
    tick();
    set_in(1, 0, 0, 0, 0, 32'h0); settle();
    n_checks++; if (stall !== 6'b000011) $display("FAIL refill_2_if_ignored: got %b want %b", stall, 6'b000011); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 32'h0); settle();
    n_checks++; if (stall !== 6'b000000) $display("FAIL refill_done_run: got %b want 0", stall); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back_flush();
    set_in(0, 0, 0, 0, 1, 32'h0000_0040); tick();
    set_in(0, 0, 0, 0, 0, 32'h0); tick();
    set_in(0, 0, 0, 0, 1, 32'h0000_0080); settle();
    n_checks++; if (stall !== 6'b111111) $display("FAIL b2b_freeze: got %b want %b", stall, 6'b111111); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 32'h0); settle();
    n_checks++; if (flush !== 1'b1) $display("FAIL b2b_flush: got %b want 1", flush); else n_pass++;
    n_checks++; if (new_pc !== 32'h80) $display("FAIL b2b_new_pc: got %h want %h", new_pc, 32'h80); else n_pass++;
    tick();
    for (int i = 0; i < REFILL_CYCLES; i++) begin
      settle();
      n_checks++; if (stall !== 6'b000011) $display("FAIL b2b_refill_%0d: got %b want %b", i, stall, 6'b000011); else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (stall !== 6'b000000) $display("FAIL b2b_run: got %b want 0", stall); else n_pass++;
    tick();
  endtask

  task automatic test_watchdog();
    int pulses;
    pulses = 0;
    do_reset();
    set_in(0, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      settle();
      if (stall_timeout === 1'b1) pulses++;
      n_checks++;
      if (stall_timeout !== (i == TIMEOUT - 1))
        $display("FAIL wd_pulse_cycle_%0d: got %b want %b", i + 1, stall_timeout, (i == TIMEOUT - 1));
      else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 32'h0); settle();
    n_checks++; if (pulses != 1) $display("FAIL wd_pulse_count: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (stall_cnt !== 32'd10) $display("FAIL wd_stall_cnt: got %0d want 10", stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_rst_refill();
    set_in(0, 0, 0, 0, 1, 32'h0000_1234); tick();
    set_in(0, 0, 0, 0, 0, 32'h0); tick();
    settle();
    n_checks++; if (stall !== 6'b000011) $display("FAIL rst_pre_refill: got %b want %b", stall, 6'b000011); else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;
    settle();
    n_checks++; if (stall !== 6'b000000) $display("FAIL rst_refill_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL rst_refill_flush: got %b want 0", flush); else n_pass++;
    n_checks++; if (stall_cnt !== 32'h0) $display("FAIL rst_refill_cnt: got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (new_pc !== 32'h0) $display("FAIL rst_refill_new_pc: got %h want 0", new_pc); else n_pass++;
    tick(); settle();
    n_checks++; if (stall !== 6'b000000) $display("FAIL rst_refill_no_resume: got %b want 0", stall); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
             $urandom_range(5) == 0, $urandom_range(9) == 0, $urandom);
      settle();
      n_checks++;
      if (stall !== exp_stall || flush !== exp_flush || new_pc !== exp_new_pc ||
          stall_cnt !== exp_stall_cnt || stall_timeout !== exp_timeout) begin
        if (errs < 10)
          $display("FAIL random_%0d: stall=%b/%b flush=%b/%b new_pc=%h/%h cnt=%0d/%0d tmo=%b/%b (got/want)",
                   i, stall, exp_stall, flush, exp_flush, new_pc, exp_new_pc,
                   stall_cnt, exp_stall_cnt, stall_timeout, exp_timeout);
        errs++;
      end else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_flush_seq();
    test_back_to_back_flush();
    test_watchdog();
    test_rst_refill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
